// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the sweep controller: state encoding.
package sweep_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4,
        S_CLR  = 3'd5
    } state_e;

endpackage

// File: rtl/univ_bin_counter.sv
// Universal up/down binary counter with sync clear and parallel load.
// Lives beside sweep_ctrl at the level above; its reset is active-high.
module univ_bin_counter #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         syn_clr_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic [N-1:0] d_i,
    output logic         max_tick_o,
    output logic         min_tick_o,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;

    // Priority: clear, load, then count in the requested direction.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)        q_q <= '0;
        else if (syn_clr_i) q_q <= '0;
        else if (load_i)    q_q <= d_i;
        else if (en_i) begin
            if (up_i) q_q <= q_q + N'(1);
            else      q_q <= q_q - N'(1);
        end
    end

    assign q_o        = q_q;
    assign max_tick_o = (q_q == {N{1'b1}});
    assign min_tick_o = (q_q == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep controller: drives a univ_bin_counter from lo up to hi and back
// down to lo, for a programmed number of sweeps (0 = run until stopped).
module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic [N-1:0] lo_i,
    input  logic [N-1:0] hi_i,
    input  logic [W-1:0] cycles_i,
    input  logic [N-1:0] q_i,
    output logic         syn_clr_o,
    output logic         load_o,
    output logic         en_o,
    output logic         up_o,
    output logic [N-1:0] d_o,
    output logic         busy_o,
    output logic         done_tick_o,
    output logic         err_tick_o,
    output logic [W-1:0] sweep_cnt_o
);

    state_e       state_q, state_d;
    logic [N-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [W-1:0] cyc_q, cyc_d, cnt_q, cnt_d, cnt_inc;
    logic         err_d;
    logic         load_q, clr_q, done_q, busy_q, err_q;
    logic         last_sweep;

    // Count as it will read once the current sweep is credited; a zero
    // cycle target never terminates.
    assign cnt_inc    = cnt_q + W'(1);
    assign last_sweep = (cyc_q != '0) && (cnt_inc == cyc_q);

    // Next-state and capture logic; stop overrides every active transition.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (lo_i < hi_i) begin
                        lo_d    = lo_i;
                        hi_d    = hi_i;
                        cyc_d   = cycles_i;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: state_d = stop_i ? S_CLR : S_UP;
            S_UP: begin
                if (stop_i)            state_d = S_CLR;
                else if (q_i == hi_q)  state_d = S_DOWN;
            end
            S_DOWN: begin
                if (stop_i) begin
                    state_d = S_CLR;
                end else if (q_i == lo_q) begin
                    cnt_d   = cnt_inc;
                    state_d = last_sweep ? S_DONE : S_UP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_CLR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured bounds and Moore outputs registered from the next state.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            cyc_q   <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            load_q  <= (state_d == S_LOAD);
            clr_q   <= (state_d == S_CLR);
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
            err_q   <= err_d;
        end
    end

    // Count enable/direction follow q so the turnaround costs no dwell cycle.
    always_comb begin
        en_o = 1'b0;
        up_o = 1'b0;
        case (state_q)
            S_UP: begin
                en_o = 1'b1;
                up_o = (q_i != hi_q);
            end
            S_DOWN: begin
                if (q_i != lo_q) begin
                    en_o = 1'b1;
                end else if (!last_sweep) begin
                    en_o = 1'b1;
                    up_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign load_o      = load_q;
    assign syn_clr_o   = clr_q;
    assign done_tick_o = done_q;
    assign busy_o      = busy_q;
    assign err_tick_o  = err_q;
    assign d_o         = lo_q;
    assign sweep_cnt_o = cnt_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl driving a 3-bit univ_bin_counter.
module tb_sweep_ctrl;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int QM   = (1 << N) - 1;
    localparam int CM   = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, stop = 1'b0;
    logic [N-1:0] lo = '0, hi = '0;
    logic [W-1:0] cyc = '0;
    logic [N-1:0] q, d;
    logic [W-1:0] scnt;
    logic         syn_clr, load, en, up, busy, done_t, err_t, max_t, min_t;

    int checks = 0;
    int fails  = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    sweep_ctrl #(.N(N), .W(W)) dut (
        .clk_i(clk), .reset_i(rst_n), .start_i(start), .stop_i(stop),
        .lo_i(lo), .hi_i(hi), .cycles_i(cyc), .q_i(q),
        .syn_clr_o(syn_clr), .load_o(load), .en_o(en), .up_o(up), .d_o(d),
        .busy_o(busy), .done_tick_o(done_t), .err_tick_o(err_t), .sweep_cnt_o(scnt)
    );

    univ_bin_counter #(.N(N)) ctr (
        .clk_i(clk), .reset_i(~rst_n), .syn_clr_i(syn_clr), .load_i(load),
        .en_i(en), .up_i(up), .d_i(d), .max_tick_o(max_t), .min_tick_o(min_t), .q_o(q)
    );

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model: phase 0 idle, 1 load, 2 sweeping, 3 done, 4 clear.
    // While sweeping, k counts cycles since the first up-count cycle and q
    // is a triangle wave of period 2*(hi-lo) starting at lo.
    int ph, k, mlo, mhi, mcyc, mcnt, mq;
    bit merr;
    int e_q, e_en, e_up, e_load, e_clr, e_busy, e_done, e_err, e_cnt;

    function automatic void model_reset();
        ph = 0; k = 0; mlo = 0; mhi = 0; mcyc = 0; mcnt = 0; mq = 0; merr = 0;
    endfunction

    function automatic void calc();
        int dd, pp, p;
        bit fin;
        e_en = 0; e_up = 0; e_load = 0; e_clr = 0; e_done = 0;
        e_busy = (ph != 0);
        e_err  = (ph == 0) && merr;
        e_q    = mq;
        e_cnt  = mcnt;
        case (ph)
            1: e_load = 1;
            2: begin
                dd    = mhi - mlo;
                pp    = 2 * dd;
                p     = k % pp;
                e_q   = mlo + ((p <= dd) ? p : pp - p);
                e_cnt = (k == 0) ? 0 : ((k - 1) / pp) & CM;
                fin   = (mcyc != 0) && (k == mcyc * pp);
                e_en  = !fin;
                e_up  = !fin && (p < dd);
            end
            3: begin e_done = 1; e_q = mlo; end
            4: e_clr = 1;
            default: ;
        endcase
    endfunction

    function automatic void advance();
        calc();
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (ph)
            0: begin
                merr = 0;
                if (start) begin
                    if (lo < hi) begin
                        mlo = lo; mhi = hi; mcyc = cyc; mcnt = 0; ph = 1;
                    end else begin
                        merr = 1;
                    end
                end
            end
            1: begin
                mq = mlo;
                if (stop) ph = 4;
                else begin ph = 2; k = 0; end
            end
            2: begin
                if (stop) begin
                    mcnt = e_cnt;
                    mq   = (e_q + (e_en ? (e_up ? 1 : -1) : 0)) & QM;
                    ph   = 4;
                end else if (!e_en) begin
                    mcnt = mcyc & CM;
                    mq   = mlo;
                    ph   = 3;
                end else begin
                    k++;
                end
            end
            3: ph = 0;
            4: begin mq = 0; ph = 0; end
            default: ph = 0;
        endcase
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            calc();
            chk("q", int'(q), e_q);
            chk("busy", int'(busy), e_busy);
            chk("load", int'(load), e_load);
            chk("syn_clr", int'(syn_clr), e_clr);
            chk("en", int'(en), e_en);
            chk("up", int'(up), e_up);
            chk("d", int'(d), mlo);
            chk("done_tick", int'(done_t), e_done);
            chk("err_tick", int'(err_t), e_err);
            chk("sweep_cnt", int'(scnt), e_cnt);
            chk("max_tick", int'(max_t), int'(e_q == QM));
        end
    end

    // One clock: model steps after the compare, inputs change after posedge.
    task automatic step();
        @(negedge clk);
        #1 advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, dones;
        model_reset();
        cmp_on = 1'b1;
        rst_n  = 1'b0;
        repeat (2) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_cnt", int'(scnt), 0);
        chk("rst_q", int'(q), 0);
        rst_n = 1'b1;
        step();

        // Single sweep 2..5: done_tick lands on cycle 9 after start.
        lo = 3'd2; hi = 3'd5; cyc = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done_t && n < 30) begin step(); n++; end
        chk("single_done_cycle", n, 9);
        chk("single_cnt", int'(scnt), 1);
        chk("single_q", int'(q), 2);
        step(); step();
        chk("single_hold_q", int'(q), 2);
        chk("single_idle", int'(busy), 0);

        // Rejected starts.
        lo = 3'd5; hi = 3'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("err_eq_tick", int'(err_t), 1);
        chk("err_eq_busy", int'(busy), 0);
        step();
        chk("err_eq_pulse", int'(err_t), 0);
        lo = 3'd6; hi = 3'd1; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("err_inv_tick", int'(err_t), 1);
        chk("err_inv_ctl", int'({load, en, syn_clr}), 0);
        step();

        // Stop in the down leg of sweep 2.
        lo = 3'd1; hi = 3'd6; cyc = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(scnt == 8'd1 && q == 3'd4 && en && !up) && n < 100) begin step(); n++; end
        chk("stop_found", int'(n < 100), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_clr", int'(syn_clr), 1);
        step();
        chk("stop_q", int'(q), 0);
        chk("stop_idle", int'(busy), 0);
        chk("stop_cnt", int'(scnt), 1);

        // Continuous 0..7, then async reset while counting up at q=3.
        lo = 3'd0; hi = 3'd7; cyc = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(scnt == 8'd2 && q == 3'd3 && up) && n < 100) begin step(); n++; end
        chk("cont_found", int'(n < 100), 1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ctl", int'({load, en, up, syn_clr}), 0);
        chk("arst_q", int'(q), 0);
        step();
        rst_n = 1'b1;
        step();

        // Start held high: restarts from IDLE after DONE.
        lo = 3'd0; hi = 3'd1; cyc = 8'd1; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_t) dones++;
        end
        start = 1'b0;
        chk("held_start_dones", dones, 2);
        repeat (6) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            lo    = N'($urandom_range(0, QM));
            hi    = N'($urandom_range(0, QM));
            cyc   = W'($urandom_range(0, 3));
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end
        start = 1'b0; stop = 1'b0; rst_n = 1'b1;
        repeat (4) step();
        cmp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
